onehot_pending_decoder: RTL

// Decode-side counterpart of the 8-input priority encoder. Accepts encoded
// {index, valid} events and rebuilds them into a registered one-hot pending

---
 rtl/onehot_pending_decoder.sv | 94 +++++++++
 1 files changed

// File: rtl/onehot_pending_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | onehot_pending_decoder: rebuilds {index,valid} set/clear events into a     |
// | registered one-hot pending vector with count/any/dup/err status.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module onehot_pending_decoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_valid,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             clr_all,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     onehot,
    output logic             any,
    output logic [3:0]       count,
    output logic             dup,
    output logic             err
);

    localparam logic [IDX_W:0] c_n_lines = (IDX_W+1)'(N);

    logic         w_set_ok;
    logic         w_clr_ok;
    logic         w_set_accept;
    logic [N-1:0] w_set_mask;
    logic [N-1:0] w_clr_mask;
    logic [N-1:0] w_next;
    logic [3:0]   w_count;
    logic         w_dup;
    logic         w_err;

    logic [N-1:0] r_pending;
    logic [N-1:0] r_onehot;
    logic         r_any;
    logic [3:0]   r_count;
    logic         r_dup;
    logic         r_err;

    assign w_set_ok     = set_valid && ({1'b0, set_idx} < c_n_lines);
    assign w_clr_ok     = clr_valid && ({1'b0, clr_idx} < c_n_lines);
    assign w_set_accept = w_set_ok && !clr_all;

    for (genvar gi = 0; gi < N; gi++) begin : g_decode
        assign w_set_mask[gi] = w_set_ok && (set_idx == IDX_W'(gi));
        assign w_clr_mask[gi] = w_clr_ok && (clr_idx == IDX_W'(gi));
    end

    // Set is OR-ed in after the clear so a set wins over a clear on the same line.
    assign w_next = clr_all ? '0 : ((r_pending & ~w_clr_mask) | w_set_mask);

    // A same-cycle clear on the line makes the set a re-arm rather than a duplicate.
    assign w_dup = w_set_accept && |(r_pending & w_set_mask & ~w_clr_mask);
    assign w_err = (set_valid && !w_set_ok) || (clr_valid && !w_clr_ok);

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N; i++) begin
            w_count = w_count + {3'b000, w_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_onehot  <= '0;
            r_any     <= 1'b0;
            r_count   <= '0;
            r_dup     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_next;
            r_onehot  <= w_set_accept ? w_set_mask : '0;
            r_any     <= |w_next;
            r_count   <= w_count;
            r_dup     <= w_dup;
            r_err     <= w_err;
        end
    end

    assign pending = r_pending;
    assign onehot  = r_onehot;
    assign any     = r_any;
    assign count   = r_count;
    assign dup     = r_dup;
    assign err     = r_err;

endmodule
`default_nettype wire
